// File: rtl/i2c_bus_ctrl.sv
// I2C bus front-end: pad synchronisation/filtering, START/STOP detection,
// bus-busy tracking, idle-gated master/slave mode switching, arbitration
// loss detection and sticky status with write-1-to-clear.
module i2c_bus_ctrl #(
    parameter int unsigned FILT_LEN = 3,
    parameter int unsigned IDLE_CYC = 16,
    parameter int unsigned SYNC_STG = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] mode_req,
    input  logic [7:0] status_clr,
    input  logic       mst_busy,
    input  logic       mst_done,
    input  logic       sda_mo,
    input  logic       scl_mo,
    input  logic       sda_so,
    input  logic       scl_so,
    output logic       sda_eng_i,
    output logic       scl_eng_i,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       scl_o,
    output logic       sda_o,
    output logic [1:0] mode_act,
    output logic       start_det,
    output logic       stop_det,
    output logic       bus_busy,
    output logic [7:0] status
);

    typedef enum logic [1:0] {ST_OFF, ST_SLV, ST_MST, ST_PEND} state_t;

    localparam int unsigned IW        = $clog2(IDLE_CYC + 1);
    localparam logic [3:0]  FILT_MAX  = 4'(FILT_LEN - 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYC - 1);
    localparam logic [IW-1:0] IDLE_SAT  = IW'(IDLE_CYC);

    logic [SYNC_STG-1:0] scl_sync, sda_sync;
    logic                scl_s, sda_s;
    logic                scl_f, sda_f, scl_q, sda_q;
    logic [3:0]          scl_cnt, sda_cnt;
    logic [IW-1:0]       idle_cnt;
    logic                bus_idle, idle_to, scl_rise, arb_cond;
    logic                arb_force, arb_lost, start_seen, stop_seen, done_seen;
    logic [1:0]          req, mode_act_n, route;
    logic                sw_ok;
    logic                unused_clr;
    state_t              state, state_n;

    assign scl_s = scl_sync[SYNC_STG-1];
    assign sda_s = sda_sync[SYNC_STG-1];
    assign unused_clr = ^status_clr[6:3];

    // Synchroniser chains for the raw pad inputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STG-2:0], scl_i};
            sda_sync <= {sda_sync[SYNC_STG-2:0], sda_i};
        end
    end

    // Glitch filters: a line flips only after FILT_LEN consecutive differing samples
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_f   <= 1'b1;
            sda_f   <= 1'b1;
            scl_q   <= 1'b1;
            sda_q   <= 1'b1;
            scl_cnt <= '0;
            sda_cnt <= '0;
        end else begin
            scl_q <= scl_f;
            sda_q <= sda_f;
            if (scl_s != scl_f) begin
                if (scl_cnt == FILT_MAX) begin
                    scl_f   <= scl_s;
                    scl_cnt <= '0;
                end else begin
                    scl_cnt <= scl_cnt + 4'd1;
                end
            end else begin
                scl_cnt <= '0;
            end
            if (sda_s != sda_f) begin
                if (sda_cnt == FILT_MAX) begin
                    sda_f   <= sda_s;
                    sda_cnt <= '0;
                end else begin
                    sda_cnt <= sda_cnt + 4'd1;
                end
            end else begin
                sda_cnt <= '0;
            end
        end
    end

    // SCL must be high in both cycles, so coincident SCL/SDA edges never detect
    assign start_det = scl_f & scl_q & sda_q & ~sda_f;
    assign stop_det  = scl_f & scl_q & ~sda_q & sda_f;
    assign scl_rise  = scl_f & ~scl_q;
    assign bus_idle  = scl_f & sda_f;
    assign idle_to   = bus_idle && (idle_cnt == IDLE_LAST);

    // Idle counter saturates so the timeout fires once per idle stretch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt <= '0;
        end else if (!bus_idle) begin
            idle_cnt <= '0;
        end else if (idle_cnt != IDLE_SAT) begin
            idle_cnt <= idle_cnt + IW'(1);
        end
    end

    // Bus-busy flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_busy <= 1'b0;
        end else if (start_det) begin
            bus_busy <= 1'b1;
        end else if (stop_det || idle_to) begin
            bus_busy <= 1'b0;
        end
    end

    function automatic state_t mode_state(input logic [1:0] m);
        case (m)
            2'b01:   return ST_SLV;
            2'b10:   return ST_MST;
            default: return ST_OFF;
        endcase
    endfunction

    assign req   = (mode_req == 2'b11) ? 2'b00 : mode_req;
    assign sw_ok = ~bus_busy & ~mst_busy;

    // Mode FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_OFF;
            mode_act <= 2'b00;
        end else begin
            state    <= state_n;
            mode_act <= mode_act_n;
        end
    end

    // Mode FSM next state: switch only when the bus and master engine are idle
    always_comb begin
        state_n    = state;
        mode_act_n = mode_act;
        case (state)
            ST_PEND: begin
                if (req == mode_act) begin
                    state_n = mode_state(mode_act);
                end else if (sw_ok) begin
                    state_n    = mode_state(req);
                    mode_act_n = req;
                end
            end
            default: begin
                if (req != mode_act) begin
                    if (sw_ok || (state == ST_OFF && !bus_busy)) begin
                        state_n    = mode_state(req);
                        mode_act_n = req;
                    end else begin
                        state_n = ST_PEND;
                    end
                end
            end
        endcase
    end

    assign arb_cond = (mode_act == 2'b10) & bus_busy & scl_rise & sda_o & ~sda_f;

    // Pad source selected by the applied mode
    always_comb begin
        route = 2'b11;
        case (mode_act)
            2'b01:   route = {scl_so, sda_so};
            2'b10:   route = {scl_mo, sda_mo};
            default: route = 2'b11;
        endcase
    end

    // Registered pad drives; released while arbitration is lost
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_o <= 1'b1;
            sda_o <= 1'b1;
        end else if (arb_force || arb_cond) begin
            scl_o <= 1'b1;
            sda_o <= 1'b1;
        end else begin
            {scl_o, sda_o} <= route;
        end
    end

    // Arbitration-loss pad release held until STOP or idle timeout
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arb_force <= 1'b0;
        end else if (arb_cond) begin
            arb_force <= 1'b1;
        end else if (stop_det || idle_to) begin
            arb_force <= 1'b0;
        end
    end

    // Sticky status bits, set has priority over clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arb_lost   <= 1'b0;
            start_seen <= 1'b0;
            stop_seen  <= 1'b0;
            done_seen  <= 1'b0;
        end else begin
            arb_lost   <= arb_cond  | (arb_lost   & ~status_clr[7]);
            start_seen <= start_det | (start_seen & ~status_clr[2]);
            stop_seen  <= stop_det  | (stop_seen  & ~status_clr[1]);
            done_seen  <= mst_done  | (done_seen  & ~status_clr[0]);
        end
    end

    assign scl_eng_i = (|mode_act) ? scl_f : 1'b1;
    assign sda_eng_i = (|mode_act) ? sda_f : 1'b1;
    assign status    = {arb_lost, bus_busy, (state == ST_PEND), mode_act,
                        start_seen, stop_seen, done_seen};

endmodule
